// File: rtl/source_decoder.sv
// source_decoder: sequential search for the lowest a with F(a,b)==c over the four candidates
module source_decoder #(
  parameter bit STOP_ON_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] c_in,
  input  logic [1:0] b_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] a_out,
  output logic       found,
  output logic       ambiguous,
  output logic [3:0] match_mask
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t     state;
  logic [1:0] c_q, b_q, idx, f;
  logic       hit;
  logic [3:0] nm;
  function automatic logic [1:0] enc(input logic [1:0] a, input logic [1:0] b);
    return a == 2'd0 ? (b == 2'b11 ? 2'b11 : 2'b00) :
           a == 2'd1 ? {b[1], 1'b1} : {~b[1], b[1]};
  endfunction
  assign in_ready = state == IDLE;
  // Evaluate the current candidate and fold it into the mask being built
  always_comb begin
    f   = enc(idx, b_q);
    hit = f == c_q;
    nm  = match_mask | ({3'b000, hit} << idx);
  end
  // Request FSM: accept, scan one candidate per cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      c_q        <= 2'b00;
      b_q        <= 2'b00;
      idx        <= 2'd0;
      out_valid  <= 1'b0;
      a_out      <= 2'b00;
      found      <= 1'b0;
      ambiguous  <= 1'b0;
      match_mask <= 4'b0000;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          c_q        <= c_in;
          b_q        <= b_in;
          idx        <= 2'd0;
          a_out      <= 2'b00;
          found      <= 1'b0;
          ambiguous  <= 1'b0;
          match_mask <= 4'b0000;
          state      <= SEARCH;
        end
        SEARCH: begin
          match_mask <= nm;
          a_out      <= nm[0] ? 2'd0 : nm[1] ? 2'd1 : nm[2] ? 2'd2 : nm[3] ? 2'd3 : 2'd0;
          found      <= |nm;
          ambiguous  <= $countones(nm) > 1;
          idx        <= idx + 2'd1;
          if (idx == 2'd3 || (STOP_ON_FIRST && hit)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_source_decoder.sv
// tb_source_decoder: randomized and directed checks of both search modes against a rule-level model
module tb_source_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] c_in = 2'b00, b_in = 2'b00;
  logic       in_valid0 = 1'b0, out_ready0 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic       in_ready0, out_valid0, found0, ambiguous0;
  logic       in_ready1, out_valid1, found1, ambiguous1;
  logic [1:0] a_out0, a_out1;
  logic [3:0] match_mask0, match_mask1;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  source_decoder #(.STOP_ON_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .c_in(c_in), .b_in(b_in),
    .out_valid(out_valid0), .out_ready(out_ready0), .a_out(a_out0), .found(found0),
    .ambiguous(ambiguous0), .match_mask(match_mask0));

  source_decoder #(.STOP_ON_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .c_in(c_in), .b_in(b_in),
    .out_valid(out_valid1), .out_ready(out_ready1), .a_out(a_out1), .found(found1),
    .ambiguous(ambiguous1), .match_mask(match_mask1));

  function automatic logic [1:0] ref_f(input int a, input logic [1:0] b);
    if (a == 0) return (b == 2'b11) ? 2'b11 : 2'b00;
    if (a == 1) return {b[1], 1'b1};
    return {~b[1], b[1]};
  endfunction

  // expected {out_valid, a_out, found, ambiguous, mask}; k = index at which the search ends
  function automatic logic [8:0] ref_res(input logic [1:0] c, input logic [1:0] b, input bit stop, output int k);
    logic [3:0] m = 4'b0000;
    int n = 0;
    int low = -1;
    k = 3;
    for (int a = 0; a < 4; a++) begin
      if (ref_f(a, b) == c) begin
        m[a] = 1'b1;
        n++;
        if (low < 0) low = a;
        if (stop) begin
          k = a;
          break;
        end
      end
    end
    return {1'b1, (low < 0) ? 2'b00 : 2'(low), n > 0, n > 1, m};
  endfunction

  task automatic run0(input logic [1:0] c, input logic [1:0] b, input int stall);
    logic [8:0] exp_r;
    int k;
    exp_r = ref_res(c, b, 1'b0, k);
    checks++;
    if (in_ready0 !== 1'b1) begin failures++; $display("FAIL ready_before_accept0 got=%b exp=1", in_ready0); end
    c_in = c; b_in = b; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; c_in = 2'($urandom); b_in = 2'($urandom);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
        failures++; $display("FAIL search0_T+%0d out_valid=%b in_ready=%b exp 0 0", i, out_valid0, in_ready0);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_valid0, a_out0, found0, ambiguous0, match_mask0} !== exp_r) begin
      failures++; $display("FAIL result0 c=%b b=%b got=%b exp=%b", c, b, {out_valid0, a_out0, found0, ambiguous0, match_mask0}, exp_r);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid0 = 1'($urandom); c_in = 2'($urandom); b_in = 2'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid0, a_out0, found0, ambiguous0, match_mask0} !== exp_r || in_ready0 !== 1'b0) begin
        failures++; $display("FAIL hold0 cycle=%0d got=%b in_ready=%b exp=%b", i, {out_valid0, a_out0, found0, ambiguous0, match_mask0}, in_ready0, exp_r);
      end
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      failures++; $display("FAIL release0 out_valid=%b in_ready=%b exp 0 1", out_valid0, in_ready0);
    end
  endtask

  task automatic run1(input logic [1:0] c, input logic [1:0] b);
    logic [8:0] exp_r;
    int k;
    exp_r = ref_res(c, b, 1'b1, k);
    c_in = c; b_in = b; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; c_in = 2'($urandom); b_in = 2'($urandom);
    for (int i = 1; i <= k + 1; i++) begin
      checks++;
      if (out_valid1 !== 1'b0) begin failures++; $display("FAIL search1_T+%0d out_valid=%b exp=0", i, out_valid1); end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_valid1, a_out1, found1, ambiguous1, match_mask1} !== exp_r) begin
      failures++; $display("FAIL result1 c=%b b=%b got=%b exp=%b", c, b, {out_valid1, a_out1, found1, ambiguous1, match_mask1}, exp_r);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      failures++; $display("FAIL release1 out_valid=%b in_ready=%b exp 0 1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({out_valid0, a_out0, found0, ambiguous0, match_mask0, in_ready0} !== 10'b0000_0000_01) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000000001", {out_valid0, a_out0, found0, ambiguous0, match_mask0, in_ready0});
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset got=%b%b exp=11", in_ready0, in_ready1);
    end
  endtask

  task automatic test_directed;
    run0(2'b01, 2'b00, 0);
    run0(2'b11, 2'b11, 0);
    run0(2'b01, 2'b10, 0);
    run0(2'b00, 2'b11, 0);
  endtask

  task automatic test_backpressure;
    run0(2'b01, 2'b10, 10);
  endtask

  task automatic test_back_to_back;
    run0(2'($urandom), 2'($urandom), 0);
    run0(2'($urandom), 2'($urandom), 0);
  endtask

  task automatic test_stop_on_first;
    run1(2'b11, 2'b11);
    run1(2'b01, 2'b10);
    run1(2'b00, 2'b11);
    for (int i = 0; i < 12; i++) run1(2'($urandom), 2'($urandom));
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) run0(2'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
  endtask

  task automatic test_reset_mid_search;
    c_in = 2'b11; b_in = 2'b11; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, a_out0, found0, ambiguous0, match_mask0, in_ready0} !== 10'b0000_0000_01) begin
      failures++; $display("FAIL reset_mid_search got=%b exp=0000000001", {out_valid0, a_out0, found0, ambiguous0, match_mask0, in_ready0});
    end
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_no_result out_valid=%b exp=0", out_valid0); end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin failures++; $display("FAIL ready_after_abort got=%b exp=1", in_ready0); end
    run0(2'b01, 2'b00, 0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_stop_on_first;
    test_reset_mid_search;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/source_decoder.md
SOURCE_DECODER -- requirements
Module: source_decoder

Interface
REQ-001 The parameter STOP_ON_FIRST SHALL have default 0; when 1, the search ends at the first matching candidate.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 c_in  input  2  encoded value to invert.
REQ-007 b_in  input  2  key operand used by the encoding.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 a_out  output  2  lowest candidate a with F(a,b)==c; 00 if none.
REQ-011 found  output  1  at least one candidate matched.
REQ-012 ambiguous  output  1  more than one candidate matched.
REQ-013 match_mask  output  4  bit i set iff F(i,b)==c.

Function
REQ-014 Encoding F(a,b) SHALL be: a=00 -> 11 if b==11, else 00; a=01 -> {b[1],1}; a=10 and a=11 -> {~b[1],b[1]}.
REQ-015 FSM states SHALL be IDLE, SEARCH, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 Accept: in_valid&&in_ready at edge T latches c_in, b_in; clears mask and index; moves to SEARCH.
REQ-018 SEARCH SHALL evaluate exactly one candidate per cycle, index 0,1,2,3 in order, on cycles T+1..T+4.
REQ-019 Each evaluated candidate i SHALL set match_mask[i] when F(i,b)==c.
REQ-020 With STOP_ON_FIRST=0, after index 3 the FSM SHALL enter DONE; out_valid first high in cycle T+5.
REQ-021 With STOP_ON_FIRST=1, a match at index k SHALL end the search; out_valid high in cycle T+k+2; higher mask bits remain 0.
REQ-022 No match after index 3 SHALL still enter DONE, with found=0, a_out=00, mask=0000, ambiguous=0.
REQ-023 a_out SHALL be the lowest set bit index of match_mask.
REQ-024 found SHALL equal |match_mask.
REQ-025 ambiguous SHALL be 1 iff popcount(match_mask)>1.
REQ-026 In DONE, out_valid SHALL be 1 and a_out, found, ambiguous, match_mask SHALL hold stable until out_valid&&out_ready.
REQ-027 On out_valid&&out_ready the FSM SHALL return to IDLE; in_ready rises the next cycle, so there is no same-cycle accept.
REQ-028 Outside DONE, out_valid SHALL be 0.
REQ-029 Input changes during SEARCH or DONE SHALL be ignored.
REQ-030 Throughput SHALL be at most one request per 6 cycles when STOP_ON_FIRST=0 and out_ready=1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, regardless of clock.
REQ-032 rst_n low SHALL force out_valid=0, a_out=00, found=0, ambiguous=0, match_mask=0000, and clear the candidate index.
REQ-033 Asserting rst_n mid-SEARCH or in DONE SHALL abort the request with no result emitted.
REQ-034 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-035 c=01, b=00, out_ready=1 -> out_valid at T+5 with mask=0010, a_out=01, found=1, ambiguous=0.
REQ-036 c=11, b=11 -> mask=0011, a_out=00, found=1, ambiguous=1; with c=01, b=10 -> mask=1100, a_out=10, ambiguous=1.
REQ-037 c=00, b=11 -> mask=0000, found=0, a_out=00, ambiguous=0, and out_valid still asserted at T+5.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE -> all outputs stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE, and in_ready=1 the next cycle.
REQ-039 STOP_ON_FIRST=1, c=11, b=11 -> out_valid at T+2, mask=0001, a_out=00, ambiguous=0.
REQ-040 Reset pulse at T+3 of a search -> outputs zero immediately, no out_valid, and in_ready=1 after release; a new request then completes normally.
